// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
//   Parametrised single-port synchronous SRAM bank with byte write enables,
//   a req/ready/rvalid handshake, a hardware clear sequencer that zeroes the
//   array after every reset, and an out-of-range error pulse.
//
// Parameters
//   DATA_W   data width in bits (multiple of 8)
//   ADDR_W   word address width in bits
//   DEPTH    number of words, 1 <= DEPTH <= 2**ADDR_W
//   READ_LAT read latency in cycles, 1 or 2
//
// Ports
//   clk        clock, rising edge
//   res        asynchronous active-low reset
//   req        request valid
//   WE         1 = write, 0 = read (sampled with req)
//   be         byte enables for writes
//   addr       word address
//   data_in    write data
//   ready      bank accepts requests (1 once the clear sequence is done)
//   rvalid     one-cycle pulse, data_out carries a read result
//   data_out   read data, holds its last value between results
//   err        one-cycle pulse for an out-of-range access
//   init_done  clear sequence complete
// -----------------------------------------------------------------------------
module sram_bank #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 1
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  req,
   input  logic                  WE,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     data_in,
   output logic                  ready,
   output logic                  rvalid,
   output logic [DATA_W-1:0]     data_out,
   output logic                  err,
   output logic                  init_done
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   logic              accept;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  clr_idx;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              vld_p1_q;
   logic              err_p1_q;
   logic [DATA_W-1:0] data_p1_q;

   assign accept   = req && (state_q == RUN);
   // Extra top bit so DEPTH == 2**ADDR_W compares correctly.
   assign in_range = ({1'b0, addr} < DEPTH_C);
   assign idx      = addr[IDX_W-1:0];
   assign clr_idx  = ptr_q[IDX_W-1:0];

   assign ready     = (state_q == RUN);
   assign init_done = (state_q == RUN);

   // Clear sequencer: one word zeroed per edge, last word moves to RUN.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         if (ptr_q == LAST_PTR) begin
            state_d = RUN;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Array: clear writes during CLEAR, byte-masked writes in RUN.
   // Out-of-range writes are dropped here; the error is flagged below.
   always_ff @(posedge clk) begin
      if (res && (state_q == CLEAR)) begin
         mem_q[clr_idx] <= '0;
      end else if (accept && WE && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

   // ---- stage p1: read result registered on the acceptance edge ----
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         vld_p1_q  <= 1'b0;
         err_p1_q  <= 1'b0;
         data_p1_q <= '0;
      end else begin
         vld_p1_q <= accept && !WE;
         err_p1_q <= accept && !in_range;
         if (accept && !WE) begin
            data_p1_q <= in_range ? mem_q[idx] : '0;
         end
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic              vld_p2_q;
         logic              err_p2_q;
         logic [DATA_W-1:0] data_p2_q;

         // ---- stage p2: extra output register for READ_LAT == 2 ----
         always_ff @(posedge clk or negedge res) begin
            if (!res) begin
               vld_p2_q  <= 1'b0;
               err_p2_q  <= 1'b0;
               data_p2_q <= '0;
            end else begin
               vld_p2_q <= vld_p1_q;
               err_p2_q <= err_p1_q;
               if (vld_p1_q) data_p2_q <= data_p1_q;
            end
         end

         assign rvalid   = vld_p2_q;
         assign err      = err_p2_q;
         assign data_out = data_p2_q;
      end else begin : g_lat1
         assign rvalid   = vld_p1_q;
         assign err      = err_p1_q;
         assign data_out = data_p1_q;
      end
   endgenerate

endmodule

// File: tb/tb_sram_bank.sv
module tb_sram_bank;

   logic        clk;
   logic        res;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [7:0]  addr;
   logic [31:0] din;

   logic        rdy0, rv0, er0, id0;
   logic [31:0] do0;
   logic        rdy1, rv1, er1, id1;
   logic [31:0] do1;
   logic        rdy2, rv2, er2, id2;
   logic [31:0] do2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 42;
   vec_t tv[NV];
   int   nv = 0;

   sram_bank u_def (
      .clk(clk), .res(res), .req(req), .WE(we), .be(be), .addr(addr),
      .data_in(din), .ready(rdy0), .rvalid(rv0), .data_out(do0), .err(er0),
      .init_done(id0)
   );

   sram_bank #(.READ_LAT(2)) u_lat2 (
      .clk(clk), .res(res), .req(req), .WE(we), .be(be), .addr(addr),
      .data_in(din), .ready(rdy1), .rvalid(rv1), .data_out(do1), .err(er1),
      .init_done(id1)
   );

   sram_bank #(.DEPTH(200)) u_d200 (
      .clk(clk), .res(res), .req(req), .WE(we), .be(be), .addr(addr),
      .data_in(din), .ready(rdy2), .rvalid(rv2), .data_out(do2), .err(er2),
      .init_done(id2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [3:0] b, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] e);
      tv[nv].we   = w;
      tv[nv].be   = b;
      tv[nv].addr = a;
      tv[nv].wd   = d;
      tv[nv].exp  = e;
      nv++;
   endtask

   task automatic drive(input logic r, input logic w, input logic [3:0] b,
                        input logic [7:0] a, input logic [31:0] d);
      req  = r;
      we   = w;
      be   = b;
      addr = a;
      din  = d;
   endtask

   initial begin
      int n;
      int n200;
      int nrv;
      logic [31:0] diag;

      res = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

      // vector table
      add(1'b0, 4'h0, 8'd0,   32'h0, 32'h0);
      add(1'b0, 4'h0, 8'd128, 32'h0, 32'h0);
      add(1'b0, 4'h0, 8'd255, 32'h0, 32'h0);
      for (int a = 0; a < 16; a++) begin
         diag = (32'h1 << (15 - a)) | (32'h1 << (15 + a));
         add(1'b1, 4'hF, 8'(a), diag, 32'h0);
      end
      for (int a = 0; a < 16; a++) begin
         diag = (32'h1 << (15 - a)) | (32'h1 << (15 + a));
         add(1'b0, 4'h0, 8'(a), 32'h0, diag);
      end
      add(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 32'h0);
      add(1'b1, 4'h5, 8'd5, 32'h11223344, 32'h0);
      add(1'b0, 4'h0, 8'd5, 32'h0, 32'hAA22CC44);
      add(1'b1, 4'hF, 8'd7, 32'hDEADBEEF, 32'h0);
      add(1'b0, 4'h0, 8'd7, 32'h0, 32'hDEADBEEF);
      add(1'b0, 4'h0, 8'd8, 32'h0, 32'h00800080);
      add(1'b0, 4'h0, 8'd9, 32'h0, 32'h01000040);

      // reset state
      repeat (5) @(negedge clk);
      chk("rst_ready", rdy0, 0);
      chk("rst_init_done", id0, 0);
      chk("rst_rvalid", rv0, 0);
      chk("rst_data_out", do0, 0);
      chk("rst_err", er0, 0);
      chk("rst_rvalid_lat2", rv1, 0);

      // clear sequence length
      res  = 1'b1;
      req  = 1'b1;   // must be ignored while ready=0
      n    = 0;
      n200 = 0;
      nrv  = 0;
      while (n < 400 && !rdy0) begin
         @(negedge clk);
         n++;
         if (rdy2 && n200 == 0) n200 = n;
         if (rv0 || er0) nrv++;
      end
      req = 1'b0;
      chk("clear_edges", n, 256);
      chk("clear_edges_d200", n200, 200);
      chk("init_done", id0, 1);
      chk("ready_lat2", rdy1, 1);
      chk("req_ignored_in_clear", nrv, 0);

      // table: lat1 checked for entry i, lat2 for entry i-1
      for (int i = 0; i < NV + 1; i++) begin
         if (i < NV) drive(1'b1, tv[i].we, tv[i].be, tv[i].addr, tv[i].wd);
         else        drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
         @(negedge clk);
         if (i < NV) begin
            chk($sformatf("v%0d_rvalid", i), rv0, !tv[i].we);
            chk($sformatf("v%0d_err", i), er0, 0);
            if (!tv[i].we) chk($sformatf("v%0d_data", i), do0, tv[i].exp);
         end else begin
            chk("tail_rvalid", rv0, 0);
         end
         if (i >= 1) begin
            chk($sformatf("v%0d_rvalid_lat2", i - 1), rv1, !tv[i-1].we);
            if (!tv[i-1].we) chk($sformatf("v%0d_data_lat2", i - 1), do1, tv[i-1].exp);
         end else begin
            chk("v0_lat2_early", rv1, 0);
         end
      end
      @(negedge clk);
      chk("tail_rvalid_lat2", rv1, 0);
      chk("data_out_hold", do0, 32'h01000040);

      // out of range on DEPTH=200
      drive(1'b1, 1'b1, 4'hF, 8'd220, 32'h12345678);
      @(negedge clk);
      chk("oor_wr_err", er2, 1);
      chk("oor_wr_rvalid", rv2, 0);
      chk("inr_wr_err", er0, 0);
      drive(1'b0, 1'b0, 4'h0, 8'd0, 32'h0);
      @(negedge clk);
      chk("oor_err_pulse", er2, 0);
      drive(1'b1, 1'b0, 4'h0, 8'd220, 32'h0);
      @(negedge clk);
      chk("oor_rd_rvalid", rv2, 1);
      chk("oor_rd_data", do2, 0);
      chk("oor_rd_err", er2, 1);
      chk("inr_rd_rvalid", rv0, 1);
      chk("inr_rd_data", do0, 32'h12345678);
      drive(1'b1, 1'b0, 4'h0, 8'd20, 32'h0);
      @(negedge clk);
      chk("rd20_rvalid", rv2, 1);
      chk("rd20_data", do2, 0);
      chk("rd20_err", er2, 0);
      drive(1'b0, 1'b0, 4'h0, 8'd0, 32'h0);
      @(negedge clk);

      // reset part way through the clear sequence
      res = 1'b0;
      @(negedge clk);
      res = 1'b1;
      repeat (100) @(negedge clk);
      chk("mid_clear_ready", rdy0, 0);
      res = 1'b0;
      @(negedge clk);
      chk("mid_clear_rst_ready", rdy0, 0);
      res = 1'b1;
      n = 0;
      while (n < 400 && !rdy0) begin
         @(negedge clk);
         n++;
      end
      chk("restart_clear_edges", n, 256);

      // data written before the reset is zeroed by the new clear
      drive(1'b1, 1'b0, 4'h0, 8'd7, 32'h0);
      @(negedge clk);
      chk("cleared_rvalid", rv0, 1);
      chk("cleared_data", do0, 0);

      // reset with reads in flight
      drive(1'b1, 1'b0, 4'h0, 8'd5, 32'h0);
      @(posedge clk);
      #2;
      res = 1'b0;
      req = 1'b0;
      #1;
      chk("inflight_rvalid", rv0, 0);
      chk("inflight_rvalid_lat2", rv1, 0);
      chk("inflight_data_out", do0, 0);
      @(negedge clk);
      res = 1'b1;
      n   = 0;
      nrv = 0;
      while (n < 400 && !rdy0) begin
         @(negedge clk);
         n++;
         if (rv0 || rv1) nrv++;
      end
      chk("inflight_no_rvalid", nrv, 0);
      chk("inflight_clear_edges", n, 256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
